// File: rtl/dm_cache_pkg.sv
// Shared types and address helpers for the direct-mapped cache controller.
package dm_cache_pkg;

    typedef enum logic [1:0] {IDLE, COMP, WB, FILL} state_t;

    // Byte-offset width: one extra bit below the word number for 16-bit words.
    function automatic int offset_w(input int words);
        return $clog2(words) + 1;
    endfunction

    function automatic int tag_w(input int addr_w, input int index_w, input int words);
        return addr_w - index_w - offset_w(words);
    endfunction

    // Byte address of word 'word' in the line {tag, index}; callers size-cast the result.
    function automatic logic [31:0] word_addr(input logic [31:0] tag, input logic [31:0] index,
                                              input logic [31:0] word, input int idx_w,
                                              input int off_w);
        return (tag << (idx_w + off_w)) | (index << off_w) | (word << 1);
    endfunction

endpackage

// File: rtl/dm_cache_if.sv
// Processor, cache-array and memory signals of the cache controller.
// master = controller side, slave = processor/array/memory side.
interface dm_cache_if #(
    parameter int ADDR_W  = 16,
    parameter int INDEX_W = 8,
    parameter int WORDS   = 4
);
    localparam int OFFSET_W = dm_cache_pkg::offset_w(WORDS);
    localparam int TAG_W    = dm_cache_pkg::tag_w(ADDR_W, INDEX_W, WORDS);

    logic [ADDR_W-1:0]   addr;
    logic                rd, wr, done, stall_out, err;
    logic                cache_en, cache_wr, cache_comp, cache_valid_in, cache_data_sel;
    logic [TAG_W-1:0]    cache_tag;
    logic [INDEX_W-1:0]  cache_index;
    logic [OFFSET_W-1:0] cache_offset;
    logic                cache_hit, cache_dirty, cache_valid;
    logic [TAG_W-1:0]    cache_tag_out;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_rd, mem_wr, mem_stall;

    modport master (
        input  addr, rd, wr, cache_hit, cache_dirty, cache_valid, cache_tag_out, mem_stall,
        output done, stall_out, err, cache_en, cache_wr, cache_comp, cache_valid_in,
               cache_data_sel, cache_tag, cache_index, cache_offset, mem_addr, mem_rd, mem_wr
    );

    modport slave (
        output addr, rd, wr, cache_hit, cache_dirty, cache_valid, cache_tag_out, mem_stall,
        input  done, stall_out, err, cache_en, cache_wr, cache_comp, cache_valid_in,
               cache_data_sel, cache_tag, cache_index, cache_offset, mem_addr, mem_rd, mem_wr
    );
endinterface

// File: rtl/fill_token_pipe.sv
// Follows outstanding fill reads: a MEM_LAT-deep shift register of {valid, word}.
// The head stage is the token whose memory data is valid this cycle; 'empty'
// means nothing is in flight behind the head.
module fill_token_pipe #(
    parameter int MEM_LAT = 2,
    parameter int WORD_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [WORD_W-1:0] push_word,
    output logic              out_vld,
    output logic [WORD_W-1:0] out_word,
    output logic              empty
);
    logic [MEM_LAT-1:0]             vld;
    logic [MEM_LAT-1:0][WORD_W-1:0] word;

    // Shift tokens one stage per cycle; reset drops anything in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld  <= '0;
            word <= '0;
        end else begin
            vld[0]  <= push;
            word[0] <= push_word;
            for (int i = 1; i < MEM_LAT; i++) begin
                vld[i]  <= vld[i-1];
                word[i] <= word[i-1];
            end
        end
    end

    assign out_vld  = vld[MEM_LAT-1];
    assign out_word = word[MEM_LAT-1];

    generate
        if (MEM_LAT == 1) begin : g_single
            assign empty = 1'b1;
        end else begin : g_deep
            assign empty = ~|vld[MEM_LAT-2:0];
        end
    endgenerate
endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped write-back / write-allocate cache controller.
// Optional hit/miss statistics: define DM_CACHE_STATS_EN.
module dm_cache_ctrl
    import dm_cache_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int INDEX_W = 8,
    parameter int WORDS   = 4,
    parameter int MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    dm_cache_if.master  bus,
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt
);
    localparam int OFFSET_W = offset_w(WORDS);
    localparam int TAG_W    = tag_w(ADDR_W, INDEX_W, WORDS);
    localparam int WORD_W   = OFFSET_W - 1;
    localparam logic [WORD_W-1:0] LAST_W = WORD_W'(WORDS - 1);

    state_t              state, state_nx;
    logic                is_wr, iss_done, iss_acc, wb_acc, tok_vld, tok_empty;
    logic [WORD_W-1:0]   wb_k, iss_k, tok_word;
    logic [TAG_W-1:0]    req_tag;
    logic [INDEX_W-1:0]  req_index;
    logic [OFFSET_W-1:0] req_offset;

    assign req_tag    = bus.addr[ADDR_W-1 -: TAG_W];
    assign req_index  = bus.addr[OFFSET_W +: INDEX_W];
    assign req_offset = bus.addr[OFFSET_W-1:0];

    assign wb_acc  = (state == WB) && !bus.mem_stall;
    assign iss_acc = (state == FILL) && !iss_done && !bus.mem_stall;

    fill_token_pipe #(.MEM_LAT(MEM_LAT), .WORD_W(WORD_W)) u_tok (
        .clk       (clk),
        .rst       (rst),
        .push      (iss_acc),
        .push_word (iss_k),
        .out_vld   (tok_vld),
        .out_word  (tok_word),
        .empty     (tok_empty)
    );

    // State register; the request type is captured while waiting in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            is_wr <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE) is_wr <= bus.wr;
        end
    end

    // Writeback and fill-issue word counters; both rewind on every lookup.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_k     <= '0;
            iss_k    <= '0;
            iss_done <= 1'b0;
        end else if (state == COMP) begin
            wb_k     <= '0;
            iss_k    <= '0;
            iss_done <= 1'b0;
        end else begin
            if (wb_acc && wb_k != LAST_W) wb_k <= wb_k + 1'b1;
            if (iss_acc) begin
                if (iss_k == LAST_W) iss_done <= 1'b1;
                else                 iss_k    <= iss_k + 1'b1;
            end
        end
    end

    // Next state and all controller outputs; fill issue and install are independent.
    always_comb begin
        state_nx           = state;
        bus.done           = 1'b0;
        bus.err            = 1'b0;
        bus.cache_en       = 1'b0;
        bus.cache_wr       = 1'b0;
        bus.cache_comp     = 1'b0;
        bus.cache_valid_in = 1'b0;
        bus.cache_data_sel = 1'b0;
        bus.cache_tag      = '0;
        bus.cache_index    = '0;
        bus.cache_offset   = '0;
        bus.mem_addr       = '0;
        bus.mem_rd         = 1'b0;
        bus.mem_wr         = 1'b0;
        case (state)
            IDLE: begin
                bus.err = bus.rd && bus.wr;
                if (bus.rd ^ bus.wr) state_nx = COMP;
            end
            COMP: begin
                bus.cache_en     = 1'b1;
                bus.cache_comp   = 1'b1;
                bus.cache_wr     = is_wr;
                bus.cache_tag    = req_tag;
                bus.cache_index  = req_index;
                bus.cache_offset = req_offset;
                if (bus.cache_hit) begin
                    bus.done = 1'b1;
                    state_nx = IDLE;
                end else if (bus.cache_valid && bus.cache_dirty) begin
                    state_nx = WB;
                end else begin
                    state_nx = FILL;
                end
            end
            WB: begin
                bus.cache_en     = 1'b1;
                bus.cache_tag    = req_tag;
                bus.cache_index  = req_index;
                bus.cache_offset = {wb_k, 1'b0};
                bus.mem_wr       = 1'b1;
                bus.mem_addr     = ADDR_W'(word_addr(32'(bus.cache_tag_out), 32'(req_index),
                                                     32'(wb_k), INDEX_W, OFFSET_W));
                if (wb_acc && wb_k == LAST_W) state_nx = FILL;
            end
            FILL: begin
                bus.cache_tag   = req_tag;
                bus.cache_index = req_index;
                if (!iss_done) begin
                    bus.mem_rd   = 1'b1;
                    bus.mem_addr = ADDR_W'(word_addr(32'(req_tag), 32'(req_index),
                                                     32'(iss_k), INDEX_W, OFFSET_W));
                end
                if (tok_vld) begin
                    bus.cache_en       = 1'b1;
                    bus.cache_wr       = 1'b1;
                    bus.cache_data_sel = 1'b1;
                    bus.cache_valid_in = 1'b1;
                    bus.cache_offset   = {tok_word, 1'b0};
                end
                // Last install: everything issued and nothing left behind the head token.
                if (iss_done && tok_vld && tok_empty) state_nx = COMP;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.stall_out = (state != IDLE) && !bus.done;

`ifdef DM_CACHE_STATS_EN
    logic replay, hit_ev, miss_ev;

    assign hit_ev  = (state == COMP) && bus.cache_hit && !replay;
    assign miss_ev = (state == COMP) && !bus.cache_hit;

    // Marks the lookup that follows a fill so it is not counted as a hit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                  replay <= 1'b0;
        else if (state == FILL && state_nx == COMP) replay <= 1'b1;
        else if (state == COMP)                    replay <= 1'b0;
    end

    // Saturating hit/miss counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit_ev && hit_cnt != 16'hFFFF)   hit_cnt  <= hit_cnt + 16'd1;
            if (miss_ev && miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
        end
    end
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif
endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Scoreboard bench for dm_cache_ctrl (ADDR_W=16, INDEX_W=8, WORDS=4, MEM_LAT=2).
// Stimulus queues expected events stamped with a cycle offset from the request;
// a negedge monitor pops and compares every event the DUT presents.
module tb_dm_cache_ctrl;
    localparam int K_WR = 0, K_WRS = 1, K_RD = 2, K_RDS = 3, K_INS = 4, K_DONE = 5, K_ERR = 6;

    typedef struct {
        int          kind;
        int          rel;
        logic [31:0] val;
    } ev_t;

    logic        clk, rst;
    logic [15:0] hit_cnt, miss_cnt;
    int          cyc, t_base, n_cmp, n_bad;
    ev_t         exp_q[$];

    bit          c_valid[256];
    bit          c_dirty[256];
    bit [4:0]    c_tag[256];

    dm_cache_if #(.ADDR_W(16), .INDEX_W(8), .WORDS(4)) bus ();

    dm_cache_ctrl #(.ADDR_W(16), .INDEX_W(8), .WORDS(4), .MEM_LAT(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.master),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Tag/valid/dirty array model.
    assign bus.cache_hit     = bus.cache_comp && c_valid[bus.cache_index] &&
                               (c_tag[bus.cache_index] == bus.cache_tag);
    assign bus.cache_valid   = c_valid[bus.cache_index];
    assign bus.cache_dirty   = c_dirty[bus.cache_index];
    assign bus.cache_tag_out = c_tag[bus.cache_index];

    always @(posedge clk) begin
        if (bus.cache_en && bus.cache_wr) begin
            if (bus.cache_comp) begin
                if (bus.cache_hit) c_dirty[bus.cache_index] <= 1'b1;
            end else begin
                c_valid[bus.cache_index] <= bus.cache_valid_in;
                c_tag[bus.cache_index]   <= bus.cache_tag;
                c_dirty[bus.cache_index] <= 1'b0;
            end
        end
    end

    function automatic string kname(input int k);
        case (k)
            K_WR:    return "mem_wr";
            K_WRS:   return "mem_wr_stalled";
            K_RD:    return "mem_rd";
            K_RDS:   return "mem_rd_stalled";
            K_INS:   return "install";
            K_DONE:  return "done";
            default: return "err";
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic push_ev(input int k, input int r, input logic [31:0] v);
        ev_t e;
        int  i;
        e.kind = k; e.rel = r; e.val = v;
        i = 0;
        while (i < exp_q.size() &&
               (exp_q[i].rel < r || (exp_q[i].rel == r && exp_q[i].kind <= k))) i++;
        exp_q.insert(i, e);
    endtask

    // Clean fill starting at r0: reads on consecutive cycles, installs MEM_LAT later.
    task automatic exp_fill(input int r0, input logic [15:0] base);
        for (int k = 0; k < 4; k++) begin
            push_ev(K_RD, r0 + k, 32'(base) + 32'(2 * k));
            push_ev(K_INS, r0 + 2 + k, 32'd64 + 32'(2 * k));
        end
    endtask

    task automatic exp_wb(input int r0, input logic [15:0] base);
        for (int k = 0; k < 4; k++) push_ev(K_WR, r0 + k, 32'(base) + 32'(2 * k));
    endtask

    task automatic chk_ev(input int k, input logic [31:0] v);
        ev_t e;
        int  r;
        r = cyc - t_base;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_%s: got @%0d val %0h, want no event", kname(k), r, v);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.rel != r || e.val != v) begin
                n_bad++;
                $display("FAIL ev_%s: got %s@%0d val %0h, want %s@%0d val %0h",
                         kname(e.kind), kname(k), r, v, kname(e.kind), e.rel, e.val);
            end
        end
    endtask

    // Monitor: report each observable event in a fixed per-cycle order.
    always @(negedge clk) begin
        if (rst) begin
            if (bus.mem_wr) chk_ev(bus.mem_stall ? K_WRS : K_WR, 32'(bus.mem_addr));
            if (bus.mem_rd) chk_ev(bus.mem_stall ? K_RDS : K_RD, 32'(bus.mem_addr));
            if (bus.cache_en && bus.cache_wr && bus.cache_data_sel)
                chk_ev(K_INS, 32'(bus.cache_valid_in) * 64 + 32'(bus.cache_comp) * 32 +
                              32'(bus.cache_offset));
            if (bus.done) chk_ev(K_DONE, 32'(bus.stall_out));
            if (bus.err)  chk_ev(K_ERR, 32'(bus.stall_out));
        end
    end

    task automatic drain(input string nm);
        chk({"leftover_", nm}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    function automatic logic [63:0] outs();
        return 64'({bus.done, bus.stall_out, bus.err, bus.cache_en, bus.cache_wr, bus.cache_comp,
                    bus.cache_valid_in, bus.cache_data_sel, bus.cache_tag, bus.cache_index,
                    bus.cache_offset, bus.mem_addr, bus.mem_rd, bus.mem_wr, hit_cnt, miss_cnt});
    endfunction

    // Issue one request and hold it until done (bounded); optional stall window.
    task automatic run_req(input logic [15:0] a, input logic w, input int st_at, input int st_len);
        bit seen;
        int r;
        @(posedge clk); #1;
        bus.addr = a; bus.rd = !w; bus.wr = w;
        t_base = cyc;
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            seen = bus.done;
            @(posedge clk); #1;
            r = cyc - t_base;
            bus.mem_stall = (r >= st_at) && (r < st_at + st_len);
        end
        bus.rd = 1'b0; bus.wr = 1'b0; bus.mem_stall = 1'b0;
        if (!seen) begin
            n_cmp++; n_bad++;
            $display("FAIL timeout_%0h: got no done in 40 cycles, want done", a);
        end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0; t_base = 0;
        rst = 1'b0;
        bus.addr = '0; bus.rd = 1'b0; bus.wr = 1'b0; bus.mem_stall = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("reset_outputs", outs(), 64'd0);
        rst = 1'b1;

        // 1: cold read miss
        exp_fill(2, 16'h1230);
        push_ev(K_DONE, 8, 0);
        run_req(16'h1234, 1'b0, 0, 0);
        drain("cold_read");

        // 2: read hit
        push_ev(K_DONE, 1, 0);
        run_req(16'h1234, 1'b0, 0, 0);
        drain("read_hit");

        // 3: write hit, then conflicting read evicts the dirty line
        push_ev(K_DONE, 1, 0);
        run_req(16'h1234, 1'b1, 0, 0);
        drain("write_hit");
        exp_wb(2, 16'h1230);
        exp_fill(6, 16'hFA30);
        push_ev(K_DONE, 12, 0);
        run_req(16'hFA34, 1'b0, 0, 0);
        drain("dirty_miss");

`ifdef DM_CACHE_STATS_EN
        chk("hit_cnt", 64'(hit_cnt), 64'd2);
        chk("miss_cnt", 64'(miss_cnt), 64'd2);
`else
        chk("hit_cnt", 64'(hit_cnt), 64'd0);
        chk("miss_cnt", 64'(miss_cnt), 64'd0);
`endif

        // 4: clean miss with a 3-cycle memory stall on word 1
        push_ev(K_RD, 2, 32'h1230);
        for (int r = 3; r < 6; r++) push_ev(K_RDS, r, 32'h1232);
        push_ev(K_RD, 6, 32'h1232);
        push_ev(K_RD, 7, 32'h1234);
        push_ev(K_RD, 8, 32'h1236);
        push_ev(K_INS, 4, 32'd64);
        push_ev(K_INS, 8, 32'd66);
        push_ev(K_INS, 9, 32'd68);
        push_ev(K_INS, 10, 32'd70);
        push_ev(K_DONE, 11, 0);
        run_req(16'h1234, 1'b0, 3, 3);
        drain("stalled_fill");

        // 5a: simultaneous rd/wr
        push_ev(K_ERR, 0, 0);
        @(posedge clk); #1;
        bus.rd = 1'b1; bus.wr = 1'b1; t_base = cyc;
        @(posedge clk); #1;
        bus.rd = 1'b0; bus.wr = 1'b0;
        chk("err_stays_idle", 64'(bus.stall_out), 64'd0);
        repeat (2) @(posedge clk);
        #1 drain("err");

        // 5b: reset in the middle of a fill
        push_ev(K_RD, 2, 32'h5678);
        @(posedge clk); #1;
        bus.addr = 16'h5678; bus.rd = 1'b1; t_base = cyc;
        repeat (2) @(posedge clk);
        #1 chk("stall_out_busy", 64'(bus.stall_out), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        #1 chk("midfill_reset_outputs", outs(), 64'd0);
        bus.rd = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        drain("pre_reset");
        exp_fill(2, 16'h5678);
        push_ev(K_DONE, 8, 0);
        run_req(16'h5678, 1'b0, 0, 0);
        drain("after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dm_cache_ctrl.md
Name: dm_cache_ctrl

Overview:
Parametrised direct-mapped, write-back, write-allocate cache controller FSM. It sits between the processor memory port and a cache data/tag array, and in front of a pipelined main memory of fixed latency. Over the current single-shot controller it adds:
- line size and address split set by parameters
- dirty-victim writeback
- pipelined line fill that overlaps memory latency
- write-miss replay
- an explicit done/stall handshake

Parameters:
ADDR_W, 16, processor/memory byte-address width
INDEX_W, 8, cache index bits
WORDS, 4, 16-bit words per line (power of 2, ≥2); OFFSET_W = log2(WORDS)+1, TAG_W = ADDR_W-INDEX_W-OFFSET_W
MEM_LAT, 2, cycles from mem_rd issue to valid read data (≥1)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
addr  in  ADDR_W  processor address, held stable until done
rd  in  1  read request
wr  in  1  write request
done  out  1  one-cycle pulse; request complete, cache output valid
stall_out  out  1  high while a request is in progress and not done
err  out  1  one-cycle pulse; rd and wr both high in IDLE
cache_en / cache_wr / cache_comp / cache_valid_in  out  1 each  cache array controls
cache_data_sel  out  1  0 = processor write data, 1 = memory read data
cache_tag  out  TAG_W  tag to cache
cache_index  out  INDEX_W  index to cache
cache_offset  out  OFFSET_W  offset to cache
cache_hit / cache_dirty / cache_valid  in  1 each  cache array status
cache_tag_out  in  TAG_W  stored tag at the index (victim tag)
mem_addr  out  ADDR_W  memory address
mem_rd  out  1  memory read request
mem_wr  out  1  memory write request
mem_stall  in  1  memory cannot accept a request this cycle
hit_cnt  out  16  hit counter (see Optional Feature)
miss_cnt  out  16  miss counter (see Optional Feature)

Behaviour:
- Reset (rst low, any time, including mid-fill): state = IDLE; all counters and in-flight tokens cleared; every output 0. Memory is reset alongside the controller.
- IDLE:
  - rd xor wr → COMP next cycle.
  - rd & wr → err = 1 for one cycle, stay in IDLE.
- COMP: cache_en = 1, cache_comp = 1, cache_wr = wr, cache_data_sel = 0.
  - Hit → done = 1 this cycle, → IDLE. A write hit sets dirty inside the array.
  - Miss with cache_valid & cache_dirty → WB.
  - Miss otherwise → FILL.
- WB: one word per cycle, k = 0..WORDS-1.
  - cache_en = 1, cache_comp = 0, cache_wr = 0, cache_offset = 2k.
  - mem_wr = 1, mem_addr = {cache_tag_out, index, 2k}.
  - k advances only when mem_stall = 0. After word WORDS-1 is accepted → FILL.
- FILL:
  - Issue side: issue mem_rd for words 0..WORDS-1 on consecutive non-stalled cycles, mem_addr = {tag, index, 2k}.
  - Tracking: a MEM_LAT-deep shift register of valid tokens and word numbers follows outstanding reads.
  - Install side: when a token emerges, cache_en = 1, cache_wr = 1, cache_data_sel = 1, cache_offset = token word.
  - cache_valid_in = 1 on every install; the dirty flag is cleared on install.
  - Issue and install overlap within a cycle.
  - mem_stall freezes issue only; tokens keep draining.
  - After the last install → COMP (replay). The replay hits; a write replay writes processor data and sets dirty.
- stall_out = 1 in every state except IDLE, and is 0 in the cycle done is high.
- Latency with mem_stall = 0: hit done 1 cycle after the request; clean miss done WORDS+MEM_LAT+2 cycles after the request; dirty miss adds WORDS cycles.
- Word counters are OFFSET_W-1 bits wide and never wrap mid-line; termination compares against WORDS-1.

Optional Feature:
- Macro: DM_CACHE_STATS_EN.
- Defined:
  - hit_cnt increments on a COMP hit that is not a replay.
  - miss_cnt increments on each COMP miss.
  - Both are 16-bit, saturate at 0xFFFF, and clear on reset.
- Undefined: ports remain present, tied to 0; no counter logic is generated.

Decomposition:
- Package dm_cache_pkg: state encoding (IDLE, COMP, WB, FILL), the OFFSET_W/TAG_W derivation functions, and the word-address concatenation helper.
- Sub-module fill_token_pipe: MEM_LAT-stage shift register of {valid, word} tokens with an empty flag.

Test Plan:
1. Cold read of 0x1234, mem_stall = 0 → miss; mem_rd at 0x1230/0x1232/0x1234/0x1236 on consecutive cycles; installs offsets 0/2/4/6 two cycles after each read; done 8 cycles after the request.
2. Read hit of 0x1234 immediately after scenario 1 → done exactly 1 cycle after rd; no mem_rd/mem_wr.
3. Write hit to 0x1234, then read 0xFA34 (same index 0x46, tag 0x1F) → COMP sees dirty victim tag 0x02; mem_wr at 0x1230..0x1236; then fill reads 0xFA30..0xFA36; done 12 cycles after the request.
4. mem_stall held high for 3 cycles during FILL issue of word 1 → mem_rd/mem_addr hold at 0x1232; token for word 0 still installs; done delayed by exactly 3 cycles.
5. rd = wr = 1 in IDLE → err pulses 1 cycle; state stays IDLE. rst low mid-FILL → all outputs 0 immediately; next read of the same address misses.
6. With DM_CACHE_STATS_EN, run scenarios 1–3 → hit_cnt = 2, miss_cnt = 2. Without the macro → both read 0.
